// File: rtl/c432_ack_pkg.sv
// rtl/c432_ack_pkg.sv - shared constants, state encoding and bus arbitration helper for the ack dispatcher
package c432_ack_pkg;

  localparam int NUM_BUS    = 3;
  localparam int CH_PER_BUS = 9;
  localparam int NUM_CH     = NUM_BUS * CH_PER_BUS;
  localparam int IDX_W      = 5;

  // Bus scan order, highest priority first: bus 0 beats bus 1 beats bus 2.
  localparam logic [1:0] BUS_PRIO [NUM_BUS] = '{2'd0, 2'd1, 2'd2};

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_REL, GAP} state_t;

  function automatic logic [1:0] winning_bus(input logic [NUM_BUS-1:0] sel);
    logic [1:0] b;
    b = BUS_PRIO[0];
    for (int k = NUM_BUS - 1; k >= 0; k--) begin
      if (sel[BUS_PRIO[k[1:0]]]) b = BUS_PRIO[k[1:0]];
    end
    return b;
  endfunction

endpackage

// File: rtl/c432_ack_onehot_dec.sv
// rtl/c432_ack_onehot_dec.sv - index to one-hot decoder with enable; out-of-range indices decode to zero
module c432_ack_onehot_dec
  import c432_ack_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/c432_ack_dispatch.sv
// rtl/c432_ack_dispatch.sv - registers the encoder winner and drives a held one-hot ack; C432_ACK_COUNT_EN adds per-bus grant counters
module c432_ack_dispatch
  import c432_ack_pkg::*;
#(
  parameter int HOLD_MAX   = 15,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 irq_valid,
  input  logic [NUM_BUS-1:0]   bus_sel,
  input  logic [3:0]           chan,
  input  logic [NUM_CH-1:0]    req_vec,
  output logic [NUM_CH-1:0]    ack,
  output logic [IDX_W-1:0]     ack_idx,
  output logic                 busy,
  output logic                 err_pulse,
  output logic                 tmo_pulse
`ifdef C432_ACK_COUNT_EN
  ,
  output logic [8*NUM_BUS-1:0] ack_cnt
`endif
);

  state_t            state, state_nx;
  logic [7:0]        hold_cnt;
  logic [3:0]        gap_cnt;
  logic              code_legal, released, hold_done, gap_done;
  logic              grant_start, ack_en, set_err, set_tmo;
  logic [1:0]        win_bus;
  logic [IDX_W-1:0]  req_idx;
  logic [NUM_CH-1:0] ack_nx;

  assign code_legal = (bus_sel != '0) && (chan < 4'(CH_PER_BUS));
  assign win_bus    = winning_bus(bus_sel);
  assign req_idx    = IDX_W'(win_bus) * IDX_W'(CH_PER_BUS) + IDX_W'(chan);
  assign released   = !req_vec[ack_idx];
  assign hold_done  = (hold_cnt == 8'(HOLD_MAX - 1));
  assign gap_done   = (gap_cnt == 4'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (irq_valid && code_legal) state_nx = GRANT;
      GRANT:    state_nx = WAIT_REL;
      WAIT_REL: if (released || hold_done) state_nx = GAP;
      GAP:      if (gap_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Release has priority over the timeout when both land in the same cycle.
  always_comb begin
    busy        = (state != IDLE);
    grant_start = (state == IDLE) && irq_valid && code_legal;
    set_err     = (state == IDLE) && irq_valid && !code_legal;
    set_tmo     = (state == WAIT_REL) && !released && hold_done;
    ack_en      = (state_nx == WAIT_REL);
  end

  c432_ack_onehot_dec u_dec (
    .idx    (ack_idx),
    .en     (ack_en),
    .onehot (ack_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= '0;
      ack_idx   <= '0;
      err_pulse <= 1'b0;
      tmo_pulse <= 1'b0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      ack       <= ack_nx;
      err_pulse <= set_err;
      tmo_pulse <= set_tmo;
      if (grant_start) ack_idx <= req_idx;
      if (state == GRANT)                      hold_cnt <= '0;
      else if (state == WAIT_REL && !hold_done) hold_cnt <= hold_cnt + 8'd1;
      if (state == WAIT_REL)                   gap_cnt <= '0;
      else if (state == GAP && !gap_done)      gap_cnt <= gap_cnt + 4'd1;
    end
  end

`ifdef C432_ACK_COUNT_EN
  for (genvar g = 0; g < NUM_BUS; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ack_cnt[8*g +: 8] <= '0;
      else if (grant_start && (win_bus == 2'(g)) && (ack_cnt[8*g +: 8] != 8'hff))
        ack_cnt[8*g +: 8] <= ack_cnt[8*g +: 8] + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c432_ack_dispatch.sv
// tb/tb_c432_ack_dispatch.sv - directed self-checking bench for c432_ack_dispatch
module tb_c432_ack_dispatch;

  logic        clk;
  logic        rst_n;
  logic        irq_valid;
  logic [2:0]  bus_sel;
  logic [3:0]  chan;
  logic [26:0] req_vec;
  logic [26:0] ack;
  logic [4:0]  ack_idx;
  logic        busy;
  logic        err_pulse;
  logic        tmo_pulse;
`ifdef C432_ACK_COUNT_EN
  logic [23:0] ack_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  c432_ack_dispatch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_valid (irq_valid),
    .bus_sel   (bus_sel),
    .chan      (chan),
    .req_vec   (req_vec),
    .ack       (ack),
    .ack_idx   (ack_idx),
    .busy      (busy),
    .err_pulse (err_pulse),
    .tmo_pulse (tmo_pulse)
`ifdef C432_ACK_COUNT_EN
    ,
    .ack_cnt   (ack_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    irq_valid = 1'b0;
    bus_sel   = 3'b000;
    chan      = 4'd0;
    req_vec   = '0;
    step();
    step();
    chk("rst_ack", {5'd0, ack}, 32'd0);
    chk("rst_idx", {27'd0, ack_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_pulse}, 32'd0);
    chk("rst_tmo", {31'd0, tmo_pulse}, 32'd0);
`ifdef C432_ACK_COUNT_EN
    chk("rst_cnt", {8'd0, ack_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // grant and release: bus 1, chan 4 -> idx 13
    irq_valid = 1'b1; bus_sel = 3'b010; chan = 4'd4; req_vec = 27'd1 << 13;
    step();
    irq_valid = 1'b0;
    chk("g1_idx", {27'd0, ack_idx}, 32'd13);
    chk("g1_ack_early", {5'd0, ack}, 32'd0);
    chk("g1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("g1_ack", {5'd0, ack}, 32'h0000_2000);
    step();
    step();
    chk("g1_ack_hold", {5'd0, ack}, 32'h0000_2000);
    req_vec = '0;
    step();
    chk("g1_ack_fall", {5'd0, ack}, 32'd0);
    chk("g1_gap1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("g1_gap2_busy", {31'd0, busy}, 32'd1);
    step();
    chk("g1_idle_busy", {31'd0, busy}, 32'd0);
    chk("g1_no_tmo", {31'd0, tmo_pulse}, 32'd0);

    // bus priority: bus 1 beats bus 2, chan 0 -> idx 9
    irq_valid = 1'b1; bus_sel = 3'b110; chan = 4'd0; req_vec = (27'd1 << 9) | (27'd1 << 18);
    step();
    irq_valid = 1'b0;
    chk("p_idx", {27'd0, ack_idx}, 32'd9);
    step();
    chk("p_ack", {5'd0, ack}, 32'h0000_0200);
    step();
    chk("p_ack_hold", {5'd0, ack}, 32'h0000_0200);
    req_vec = '0;
    wait_idle("p_idle");

    // illegal codes
    irq_valid = 1'b1; bus_sel = 3'b001; chan = 4'd9;
    step();
    irq_valid = 1'b0;
    chk("ill_ch_err", {31'd0, err_pulse}, 32'd1);
    chk("ill_ch_busy", {31'd0, busy}, 32'd0);
    chk("ill_ch_ack", {5'd0, ack}, 32'd0);
    step();
    chk("ill_ch_err_end", {31'd0, err_pulse}, 32'd0);
    irq_valid = 1'b1; bus_sel = 3'b000; chan = 4'd0;
    step();
    irq_valid = 1'b0;
    chk("ill_bus_err", {31'd0, err_pulse}, 32'd1);
    chk("ill_bus_busy", {31'd0, busy}, 32'd0);
    step();
    chk("ill_bus_err_end", {31'd0, err_pulse}, 32'd0);
    chk("ill_bus_ack", {5'd0, ack}, 32'd0);

    // timeout: bus 2, chan 8 -> idx 26, request held
    irq_valid = 1'b1; bus_sel = 3'b100; chan = 4'd8; req_vec = 27'd1 << 26;
    step();
    irq_valid = 1'b0;
    chk("t_idx", {27'd0, ack_idx}, 32'd26);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t_ack_held", {5'd0, ack}, 32'h0400_0000);
      chk("t_no_tmo_yet", {31'd0, tmo_pulse}, 32'd0);
    end
    step();
    chk("t_ack_fall", {5'd0, ack}, 32'd0);
    chk("t_tmo", {31'd0, tmo_pulse}, 32'd1);
    chk("t_busy_gap", {31'd0, busy}, 32'd1);
    step();
    chk("t_tmo_end", {31'd0, tmo_pulse}, 32'd0);
    wait_idle("t_idle");
    req_vec = '0;

    // release in the 15th hold cycle beats the timeout
    irq_valid = 1'b1; bus_sel = 3'b100; chan = 4'd8; req_vec = 27'd1 << 26;
    step();
    irq_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("r15_ack", {5'd0, ack}, 32'h0400_0000);
    req_vec = '0;
    step();
    chk("r15_ack_fall", {5'd0, ack}, 32'd0);
    chk("r15_no_tmo", {31'd0, tmo_pulse}, 32'd0);
    wait_idle("r15_idle");

    // async reset mid-hold on idx 5
    irq_valid = 1'b1; bus_sel = 3'b001; chan = 4'd5; req_vec = 27'd1 << 5;
    step();
    irq_valid = 1'b0;
    step();
    chk("rs_ack", {5'd0, ack}, 32'h0000_0020);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_ack_drop", {5'd0, ack}, 32'd0);
    chk("rs_busy_drop", {31'd0, busy}, 32'd0);
    chk("rs_idx_drop", {27'd0, ack_idx}, 32'd0);
    req_vec = '0;
    step();
    rst_n = 1'b1;
    step();
    irq_valid = 1'b1; bus_sel = 3'b001; chan = 4'd2; req_vec = 27'd1 << 2;
    step();
    irq_valid = 1'b0;
    chk("rs_new_idx", {27'd0, ack_idx}, 32'd2);
    step();
    chk("rs_new_ack", {5'd0, ack}, 32'h0000_0004);
    req_vec = '0;
    wait_idle("rs_new_idle");

`ifdef C432_ACK_COUNT_EN
    chk("cnt_after_rst", {8'd0, ack_cnt}, 32'h0000_0001);
    for (int i = 0; i < 300; i++) begin
      irq_valid = 1'b1; bus_sel = 3'b001; chan = 4'd0;
      step();
      irq_valid = 1'b0;
      wait_idle("cnt_loop_idle");
    end
    chk("cnt_sat", {8'd0, ack_cnt}, 32'h0000_00ff);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/c432_ack_dispatch.md
Name: c432_ack_dispatch

Overview:
- Consumer end of the 27-channel, 3-bus priority interrupt encoder, which produces three bus-level flags and a 4-bit in-bus channel code.
- Takes the winning request as bus-select plus channel, registers it, and decodes it back to a one-hot acknowledge on the granted requester line.
- Holds the acknowledge until the requester releases or a timeout fires, then enforces a re-arm gap.
- Sits between the combinational priority encoder and the 27 requesting sources.

Parameters:
- NUM_BUS, 3, number of request buses; bus 0 has highest priority.
- CH_PER_BUS, 9, channels per bus; channel 0 has highest priority.
- HOLD_MAX, 15, maximum WAIT_REL cycles before a timeout; range 1..255.
- GAP_CYCLES, 2, cycles with ack low after release before the next grant; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_valid  in  1  encoder reports at least one pending request.
- bus_sel  in  NUM_BUS  bus flags from the encoder; lowest set bit wins.
- chan  in  4  in-bus channel code from the encoder.
- req_vec  in  NUM_BUS*CH_PER_BUS  live request lines; index = bus*CH_PER_BUS+chan.
- ack  out  NUM_BUS*CH_PER_BUS  one-hot acknowledge.
- ack_idx  out  5  registered granted index.
- busy  out  1  high in every state except IDLE.
- err_pulse  out  1  one-cycle pulse on an illegal code.
- tmo_pulse  out  1  one-cycle pulse on a hold timeout.
- ack_cnt  out  8*NUM_BUS  present only with ACK_COUNT_EN.

Behaviour:
- Reset: every output is 0, including ack_cnt; state=IDLE; all counters 0. Reset asserted mid-operation drops ack asynchronously, on the same edge.
- IDLE:
  - Sample when irq_valid=1.
  - Legal code: bus_sel!=0 and chan<CH_PER_BUS. Then b = index of the lowest set bit of bus_sel, idx = b*CH_PER_BUS+chan. Register ack_idx=idx and go to GRANT.
  - bus_sel==0 or chan>=CH_PER_BUS: err_pulse=1 for one cycle, stay in IDLE.
  - irq_valid=0: stay in IDLE.
- GRANT: ack[ack_idx]=1 from the next edge, so ack rises 2 cycles after irq_valid is sampled. Clear the hold counter and go to WAIT_REL.
- WAIT_REL:
  - ack stays held; hold counter increments every cycle.
  - req_vec[ack_idx]==0: go to GAP; ack falls on that edge.
  - Hold counter reaches HOLD_MAX with the request still high: tmo_pulse=1, go to GAP.
  - If release and timeout occur in the same cycle, release wins and there is no tmo_pulse.
- GAP:
  - ack=0; irq_valid is ignored.
  - Gap counter counts GAP_CYCLES, then the block returns to IDLE. The next grant can be sampled on the first IDLE cycle.
- Only one ack bit is ever set. ack changes only at clock edges.
- Inputs changing after the IDLE sample have no effect on the grant in progress.
- Counter widths: hold counter 8 bits, gap counter 4 bits; neither wraps, since both are compared before increment.

Optional Feature:
- Macro: C432_ACK_COUNT_EN.
- Defined:
  - Per-bus 8-bit saturating grant counters packed into ack_cnt, with bus0 in [7:0].
  - A counter increments on GRANT entry and saturates at 255.
  - Counters clear only on reset.
- Undefined: the ack_cnt port and its counters do not exist; all other behaviour is identical.

Decomposition:
- Package c432_ack_pkg:
  - state enum {IDLE, GRANT, WAIT_REL, GAP};
  - NUM_CH=27 constant;
  - IDX_W=5 constant;
  - bus priority order constant.
- Sub-module c432_ack_onehot_dec: combinational index-to-NUM_CH one-hot decoder with enable, instantiated once for ack.

Test Plan:
- Grant and release: irq_valid=1, bus_sel=3'b010, chan=4 -> ack_idx=13 and ack[13]=1 two cycles later; drop req_vec[13] -> ack=0 on the next edge; busy falls after 2 GAP cycles.
- Priority between buses: bus_sel=3'b110, chan=0 -> ack[9] only (bus 1 wins); ack[18] never asserts.
- Illegal code: bus_sel=3'b001, chan=9 -> err_pulse for one cycle, ack stays 0, busy stays 0. bus_sel=0 with irq_valid=1 gives the same result.
- Timeout: bus_sel=3'b100, chan=8, req_vec[26] held high -> ack[26] high for 15 cycles, tmo_pulse once, then GAP and IDLE. Release in cycle 15 -> no tmo_pulse.
- Reset mid-WAIT_REL: pull rst_n low while ack[5]=1 -> ack=0 immediately; after release of reset, a new request grants normally.
- C432_ACK_COUNT_EN defined: 300 grants on bus 0 -> ack_cnt[7:0]=255, other bytes 0.
